// File: rtl/btb_update_ctrl.sv
// BTB write-port sequencer: FIFO-buffered EX updates plus a full invalidate sweep on flush.
// Optional statistics counters are enabled by defining BTB_CTRL_STATS_EN.
module btb_update_ctrl #(
    parameter int SET_LEN = 6,
    parameter int DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        upd_valid,
    input  logic        upd_taken,
    input  logic [29:0] upd_entry,
    input  logic [31:0] upd_target,
    output logic        upd_ready,
    input  logic        flush_req,
    output logic        flush_busy,
    output logic        pred_inhibit,
    output logic        btb_we,
    output logic        btb_real,
    output logic [29:0] btb_entry,
    output logic [31:0] btb_target
`ifdef BTB_CTRL_STATS_EN
    ,
    output logic [31:0] stat_insert,
    output logic [31:0] stat_inval,
    output logic [15:0] stat_sweeps,
    output logic [31:0] stat_fullcyc
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [SET_LEN-1:0] IDX_LAST = {SET_LEN{1'b1}};
    localparam logic [SET_LEN-1:0] IDX_ONE  = SET_LEN'(1);
    localparam logic [PTR_W-1:0]   PTR_ONE  = PTR_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t             state_r;
    logic [SET_LEN-1:0] sweep_idx_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               fifo_taken_r  [DEPTH];
    logic [29:0]        fifo_entry_r  [DEPTH];
    logic [31:0]        fifo_target_r [DEPTH];
    logic               flush_busy_r;
    logic               btb_we_r;
    logic               btb_real_r;
    logic [29:0]        btb_entry_r;
    logic [31:0]        btb_target_r;

    logic               full_s;
    logic               empty_s;
    logic               idle_s;
    logic               accept_s;
    logic               start_sweep_s;
    logic               pop_s;
    logic               bypass_s;
    logic               push_s;
    logic               issue_s;
    logic               issue_taken_s;
    logic [29:0]        issue_entry_s;
    logic [31:0]        issue_target_s;
    logic [SET_LEN-1:0] sweep_next_s;

    assign full_s        = (count_r == CNT_W'(DEPTH));
    assign empty_s       = (count_r == {CNT_W{1'b0}});
    assign idle_s        = (state_r == ST_IDLE);
    assign accept_s      = upd_valid & ~full_s;
    assign start_sweep_s = idle_s & flush_req;
    assign pop_s         = idle_s & ~flush_req & ~empty_s;
    // An update arriving at an empty, idle FIFO goes straight to the write port.
    assign bypass_s      = idle_s & ~flush_req & empty_s & accept_s;
    assign push_s        = accept_s & ~start_sweep_s & ~bypass_s;
    assign issue_s       = pop_s | bypass_s;
    assign sweep_next_s  = sweep_idx_r + IDX_ONE;

    assign upd_ready    = ~full_s;
    assign flush_busy   = flush_busy_r;
    assign pred_inhibit = flush_busy_r;
    assign btb_we       = btb_we_r;
    assign btb_real     = btb_real_r;
    assign btb_entry    = btb_entry_r;
    assign btb_target   = btb_target_r;

    // Select the write source: FIFO head when queued, otherwise the incoming update.
    always_comb begin
        issue_taken_s  = upd_taken;
        issue_entry_s  = upd_entry;
        issue_target_s = upd_target;
        if (pop_s) begin
            issue_taken_s  = fifo_taken_r[rd_ptr_r];
            issue_entry_s  = fifo_entry_r[rd_ptr_r];
            issue_target_s = fifo_target_r[rd_ptr_r];
        end else begin
            issue_taken_s  = upd_taken;
            issue_entry_s  = upd_entry;
            issue_target_s = upd_target;
        end
    end

    // FIFO pointers and occupancy; a flush in IDLE discards everything pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (start_sweep_s) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // FIFO payload storage.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_taken_r[wr_ptr_r]  <= upd_taken;
            fifo_entry_r[wr_ptr_r]  <= upd_entry;
            fifo_target_r[wr_ptr_r] <= upd_target;
        end
    end

    // Control FSM and registered BTB write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            sweep_idx_r  <= {SET_LEN{1'b0}};
            flush_busy_r <= 1'b0;
            btb_we_r     <= 1'b0;
            btb_real_r   <= 1'b0;
            btb_entry_r  <= 30'h0;
            btb_target_r <= 32'h0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (flush_req) begin
                        state_r      <= ST_SWEEP;
                        sweep_idx_r  <= {SET_LEN{1'b0}};
                        flush_busy_r <= 1'b1;
                        btb_we_r     <= 1'b1;
                        btb_real_r   <= 1'b0;
                        btb_entry_r  <= 30'h0;
                    end else if (issue_s) begin
                        btb_we_r    <= 1'b1;
                        btb_real_r  <= issue_taken_s;
                        btb_entry_r <= issue_entry_s;
                        if (issue_taken_s) begin
                            btb_target_r <= issue_target_s;
                        end
                    end else begin
                        btb_we_r <= 1'b0;
                    end
                end
                ST_SWEEP: begin
                    if (sweep_idx_r == IDX_LAST) begin
                        state_r      <= ST_IDLE;
                        sweep_idx_r  <= {SET_LEN{1'b0}};
                        flush_busy_r <= 1'b0;
                        btb_we_r     <= 1'b0;
                    end else begin
                        sweep_idx_r <= sweep_next_s;
                        btb_we_r    <= 1'b1;
                        btb_real_r  <= 1'b0;
                        btb_entry_r <= {{(30-SET_LEN){1'b0}}, sweep_next_s};
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    sweep_idx_r  <= {SET_LEN{1'b0}};
                    flush_busy_r <= 1'b0;
                    btb_we_r     <= 1'b0;
                end
            endcase
        end
    end

`ifdef BTB_CTRL_STATS_EN
    // Event counters; sweep writes never count as single-entry invalidates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_insert  <= 32'h0;
            stat_inval   <= 32'h0;
            stat_sweeps  <= 16'h0;
            stat_fullcyc <= 32'h0;
        end else begin
            if (issue_s && issue_taken_s) begin
                stat_insert <= stat_insert + 32'd1;
            end
            if (issue_s && !issue_taken_s) begin
                stat_inval <= stat_inval + 32'd1;
            end
            if ((state_r == ST_SWEEP) && (sweep_idx_r == IDX_LAST)) begin
                stat_sweeps <= stat_sweeps + 16'd1;
            end
            if (upd_valid && full_s) begin
                stat_fullcyc <= stat_fullcyc + 32'd1;
            end
        end
    end
`endif

endmodule
